// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage with IF/ID register, one-entry skid buffer and branch redirect.
// Optional misaligned-branch fault: define FETCH_ALIGN_CHECK_EN.
//
// state | meaning
// FETCH | requesting imem_addr=pc; acked words go to IF/ID (or to buffer under stall)
// HELD  | one fetched word waits in the skid buffer for the stall to drop; no request
// FAULT | misaligned branch seen; halted until reset
module fetch_stage #(
   parameter int                ADDR_W   = 64,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              if_id_valid,
   output logic [31:0]       if_id_instr,
   output logic [ADDR_W-1:0] if_id_pc,
   output logic [10:0]       if_id_opcode,
   output logic              misalign_fault
);

   typedef enum logic [1:0] {FETCH, HELD, FAULT} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic [ADDR_W-1:0] if_id_pc_nx;
   logic [31:0]       if_id_instr_nx;
   logic              if_id_valid_nx;
   logic [31:0]       buf_instr, buf_instr_nx;
   logic [ADDR_W-1:0] buf_pc, buf_pc_nx;
   logic              fault_q, fault_nx;
   logic              target_bad;
   logic [ADDR_W-1:0] redirect_pc;

   assign redirect_pc = {branch_target[ADDR_W-1:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
   assign target_bad     = (branch_target[1:0] != 2'b00);
   assign misalign_fault = fault_q;
`else
   assign target_bad     = 1'b0;
   assign misalign_fault = 1'b0;
`endif

   assign imem_addr    = pc;
   assign imem_req     = (state == FETCH) && !rst;
   assign if_id_opcode = if_id_instr[31:21];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         if_id_pc    <= '0;
         buf_instr   <= '0;
         buf_pc      <= '0;
         fault_q     <= 1'b0;
      end else begin
         state       <= state_nx;
         pc          <= pc_nx;
         if_id_valid <= if_id_valid_nx;
         if_id_instr <= if_id_instr_nx;
         if_id_pc    <= if_id_pc_nx;
         buf_instr   <= buf_instr_nx;
         buf_pc      <= buf_pc_nx;
         fault_q     <= fault_nx;
      end
   end

   always_comb begin
      state_nx       = state;
      pc_nx          = pc;
      if_id_valid_nx = if_id_valid;
      if_id_instr_nx = if_id_instr;
      if_id_pc_nx    = if_id_pc;
      buf_instr_nx   = buf_instr;
      buf_pc_nx      = buf_pc;
      fault_nx       = fault_q;

      case (state)
         FETCH: begin
            if (branch_taken) begin
               if_id_valid_nx = 1'b0;
               if_id_instr_nx = '0;
               if (target_bad) begin
                  fault_nx = 1'b1;
                  state_nx = FAULT;
               end else begin
                  pc_nx = redirect_pc;
               end
            end else if (imem_ack) begin
               pc_nx = pc + ADDR_W'(4);
               if (stall) begin
                  buf_instr_nx = imem_rdata;
                  buf_pc_nx    = pc;
                  state_nx     = HELD;
               end else begin
                  if_id_valid_nx = 1'b1;
                  if_id_instr_nx = imem_rdata;
                  if_id_pc_nx    = pc;
               end
            end else if (!stall) begin
               if_id_valid_nx = 1'b0;
               if_id_instr_nx = '0;
            end
         end
         HELD: begin
            if (branch_taken) begin
               if_id_valid_nx = 1'b0;
               if_id_instr_nx = '0;
               if (target_bad) begin
                  fault_nx = 1'b1;
                  state_nx = FAULT;
               end else begin
                  pc_nx    = redirect_pc;
                  state_nx = FETCH;
               end
            end else if (!stall) begin
               if_id_valid_nx = 1'b1;
               if_id_instr_nx = buf_instr;
               if_id_pc_nx    = buf_pc;
               state_nx       = FETCH;
            end
         end
         FAULT: begin
            state_nx = FAULT;
         end
         default: state_nx = FETCH;
      endcase
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a stream-level model predicts which (instr, pc) pairs
// enter IF/ID, in order; a monitor checks every cycle against that queue.
module tb_fetch_stage;
   localparam int AW = 64;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] imem_addr;
   logic          imem_req;
   logic          imem_ack = 1'b0;
   logic [31:0]   imem_rdata;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [AW-1:0] branch_target = '0;
   logic          if_id_valid;
   logic [31:0]   if_id_instr;
   logic [AW-1:0] if_id_pc;
   logic [10:0]   if_id_opcode;
   logic          misalign_fault;

   fetch_stage #(.ADDR_W(AW), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
      .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
      .if_id_opcode(if_id_opcode), .misalign_fault(misalign_fault)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return 32'hF840_0000 + a[31:0];
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   typedef struct packed {
      logic [31:0]   instr;
      logic [AW-1:0] pc;
   } ent_t;

   ent_t          q[$];
   logic [AW-1:0] m_pc = '0;
   bit            m_held = 1'b0;
   bit            m_fault = 1'b0;
   ent_t          m_buf;
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; the model advances on the edge the stimulus is sampled.
   task automatic step(input bit b, input logic [AW-1:0] t, input bit s, input bit a);
      ent_t e;
      @(negedge clk);
      branch_taken  = b;
      branch_target = t;
      stall         = s;
      imem_ack      = a;
      @(posedge clk);
      if (m_fault) begin
      end else if (b) begin
         m_held = 1'b0;
         if (ALIGN_EN && t[1:0] != 2'b00) m_fault = 1'b1;
         else m_pc = {t[AW-1:2], 2'b00};
      end else if (m_held) begin
         if (!s) begin
            q.push_back(m_buf);
            m_held = 1'b0;
         end
      end else if (a) begin
         e.instr = mem_word(m_pc);
         e.pc    = m_pc;
         if (s) begin
            m_buf  = e;
            m_held = 1'b1;
         end else begin
            q.push_back(e);
         end
         m_pc = m_pc + 64'd4;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"}, imem_req, 0);
      chk({tag, "_addr"}, imem_addr, 0);
      chk({tag, "_valid"}, if_id_valid, 0);
      chk({tag, "_instr"}, if_id_instr, 0);
      chk({tag, "_pc"}, if_id_pc, 0);
      chk({tag, "_fault"}, misalign_fault, 0);
   endtask

   // Monitor: compares DUT outputs against the model and the expected-entry queue.
   initial begin
      bit            pb, ps;
      bit            hv;
      logic [31:0]   hi;
      logic [AW-1:0] hp;
      ent_t          e;
      hv = 1'b0; hi = '0; hp = '0;
      forever begin
         @(posedge clk);
         pb = branch_taken;
         ps = stall;
         #1;
         if (!mon_en) begin
            hv = 1'b0; hi = '0;
         end else begin
            chk("imem_req", imem_req, !(m_held || m_fault));
            if (imem_req) chk("imem_addr", imem_addr, m_pc);
            chk("misalign_fault", misalign_fault, m_fault);
            if (pb) begin
               chk("flush_valid", if_id_valid, 0);
               chk("flush_instr", if_id_instr, 0);
               hv = 1'b0; hi = '0;
            end else if (ps) begin
               chk("hold_valid", if_id_valid, hv);
               chk("hold_instr", if_id_instr, hi);
               if (hv) chk("hold_pc", if_id_pc, hp);
            end else if (if_id_valid) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_instr actual=%h/%h expected=none", if_id_instr, if_id_pc);
               end else begin
                  e = q.pop_front();
                  chk("ifid_instr", if_id_instr, e.instr);
                  chk("ifid_pc", if_id_pc, e.pc);
                  chk("ifid_opcode", if_id_opcode, e.instr[31:21]);
                  hv = 1'b1; hi = e.instr; hp = e.pc;
               end
            end else begin
               chk("bubble_instr", if_id_instr, 0);
               hv = 1'b0; hi = '0;
            end
            chk("queue_pending", q.size(), 0);
         end
      end
   end

   initial begin
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;

      step(0, 0, 0, 1);
      #1;
      chk("first_opcode", if_id_opcode, 11'h7C2);
      chk("first_pc", if_id_pc, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 1, 1);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);

      step(1, 64'h100, 1, 1);
      step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      step(1, 64'h100, 1, 1);
      #1;
      chk("redirect_addr", imem_addr, 64'h100);

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      step(1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      #1;
      chk("wrap_pc", if_id_pc, 0);

      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] t;
         t = {$urandom, $urandom};
         t[1:0] = 2'b00;
         step($urandom_range(0, 19) == 0, t, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      step(0, 0, 1, 1);
      @(negedge clk);
      branch_taken = 1'b0;
      stall        = 1'b0;
      imem_ack     = 1'b0;
      #2;
      rst    = 1'b1;
      mon_en = 1'b0;
      #1;
      check_reset_outputs("midheld_reset");
      q.delete();
      m_pc = '0; m_held = 1'b0; m_fault = 1'b0;
      @(negedge clk);
      rst    = 1'b0;
      mon_en = 1'b1;
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);

      step(1, 64'h102, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      #1;
      chk("misalign_fault_final", misalign_fault, ALIGN_EN);
      chk("misalign_req_final", imem_req, !ALIGN_EN);
      @(negedge clk);
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
